// File: rtl/unsigned_16by8_seq_div.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per cycle.
// Build option UDIV_SATURATE_EN: error results report an all-ones quotient instead of zero.
module unsigned_16by8_seq_div #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_zero,
  output logic           overflow,
  output logic [1:0]     dbg_state
);

  localparam int CW = $clog2(N);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

`ifdef UDIV_SATURATE_EN
  localparam logic [N-1:0] ERR_Q = {N{1'b1}};
`else
  localparam logic [N-1:0] ERR_Q = '0;
`endif

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // the producer holds its payload stable while valid is high and ready is low.
  logic [1:0]    state_q, state_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  lo_q, lo_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [N-1:0]  qacc_q, qacc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  q_out_q, q_out_d;
  logic [N-1:0]  r_out_q, r_out_d;
  logic          dz_q, dz_d;
  logic          ov_q, ov_d;

  logic [N:0]    trial;
  logic          trial_ge;
  logic [N-1:0]  rem_next;

  // Restoring step: the partial remainder stays below the divisor, so T - divisor fits in N bits.
  always_comb begin
    trial    = {rem_q, lo_q[N-1]};
    trial_ge = (trial >= {1'b0, dvs_q});
    rem_next = trial_ge ? (trial[N-1:0] - dvs_q) : trial[N-1:0];
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    lo_d    = lo_q;
    dvs_d   = dvs_q;
    qacc_d  = qacc_q;
    cnt_d   = cnt_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (divisor == '0) begin
            dz_d    = 1'b1;
            ov_d    = 1'b0;
            q_out_d = ERR_Q;
            r_out_d = '0;
            state_d = S_DONE;
          end else if (dividend[2*N-1:N] >= divisor) begin
            dz_d    = 1'b0;
            ov_d    = 1'b1;
            q_out_d = ERR_Q;
            r_out_d = '0;
            state_d = S_DONE;
          end else begin
            rem_d   = dividend[2*N-1:N];
            lo_d    = dividend[N-1:0];
            dvs_d   = divisor;
            qacc_d  = '0;
            cnt_d   = CW'(N - 1);
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d  = rem_next;
        lo_d   = lo_q << 1;
        qacc_d = {qacc_q[N-2:0], trial_ge};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          q_out_d = {qacc_q[N-2:0], trial_ge};
          r_out_d = rem_next;
          dz_d    = 1'b0;
          ov_d    = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      lo_q    <= '0;
      dvs_q   <= '0;
      qacc_q  <= '0;
      cnt_q   <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      lo_q    <= lo_d;
      dvs_q   <= dvs_d;
      qacc_q  <= qacc_d;
      cnt_q   <= cnt_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign quotient  = q_out_q;
  assign remainder = r_out_q;
  assign div_zero  = dz_q;
  assign overflow  = ov_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_unsigned_16by8_seq_div.sv
// Bench for unsigned_16by8_seq_div: directed cases, backpressure, reset abort and a random sweep
// checked against a plain-arithmetic reference model; honours UDIV_SATURATE_EN.
`timescale 1ns/1ps
module tb_unsigned_16by8_seq_div;

`ifdef UDIV_SATURATE_EN
  localparam logic [7:0] ERR_Q = 8'hFF;
`else
  localparam logic [7:0] ERR_Q = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_zero;
  logic        overflow;
  logic [1:0]  dbg_state;

  unsigned_16by8_seq_div #(.N(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero), .overflow(overflow),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [17:0] exp_q[$];   // {div_zero, overflow, quotient, remainder}
  int          acc_q[$];   // cycle number of the accept
  int checks = 0;
  int errors = 0;
  bit seen_v = 1'b0;
  bit rand_rdy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the exact quotient is checked against the N-bit range directly.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [7:0] b);
    int unsigned ai, bi, qi, ri;
    ai = a;
    bi = b;
    if (bi == 0) return {1'b1, 1'b0, ERR_Q, 8'h00};
    qi = ai / bi;
    ri = ai % bi;
    if (qi > 255) return {1'b0, 1'b1, ERR_Q, 8'h00};
    return {1'b0, 1'b0, qi[7:0], ri[7:0]};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      seen_v = 1'b0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: out_valid=1 with no outstanding op (cycle %0d)", cyc);
      end else begin
        check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
        if (!seen_v) begin
          check("latency", cyc - acc_q[0], (exp_q[0][17] | exp_q[0][16]) ? 1 : 9);
          seen_v = 1'b1;
        end
        check("quotient", {24'd0, quotient}, {24'd0, exp_q[0][15:8]});
        check("remainder", {24'd0, remainder}, {24'd0, exp_q[0][7:0]});
        check("div_zero", {31'd0, div_zero}, {31'd0, exp_q[0][17]});
        check("overflow", {31'd0, overflow}, {31'd0, exp_q[0][16]});
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          seen_v = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [15:0] a, input logic [7:0] b);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", n);
    end else begin
      exp_q.push_back(model(a, b));
      acc_q.push_back(cyc);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  task automatic check_reset_values();
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_quotient", {24'd0, quotient}, 32'd0);
    check("rst_remainder", {24'd0, remainder}, 32'd0);
    check("rst_div_zero", {31'd0, div_zero}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] dir_a[10] = '{16'h3039, 16'hFE01, 16'h0000, 16'h1234, 16'h8000,
                             16'h0FFF, 16'h00FF, 16'h0100, 16'hFFFF, 16'h7FFF};
  logic [7:0]  dir_b[10] = '{8'h7B, 8'hFF, 8'h01, 8'h00, 8'h10,
                             8'h10, 8'h01, 8'h01, 8'hFF, 8'h80};

  initial begin
    logic [15:0] a;
    logic [7:0]  b;
    int unsigned lim;
    int          n;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_values();

    for (int i = 0; i < 10; i++) send(dir_a[i], dir_b[i]);
    drain();

    // in_valid with junk operands while the divider is busy must be ignored
    send(16'h2710, 8'h64);
    in_valid = 1'b1;
    dividend = 16'h0000;
    divisor  = 8'h00;
    repeat (5) @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    // backpressure: hold out_ready low for 5 cycles in DONE
    out_ready = 1'b0;
    send(16'h1F40, 8'h3C);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid_seen", {31'd0, out_valid}, 32'd1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

    // reset in the 4th CALC cycle aborts the op
    send(16'h3039, 8'h7B);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    check_reset_values();
    repeat (12) @(negedge clk);
    send(16'h0064, 8'h0A);
    drain();

    // random sweep with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      n = $urandom_range(0, 9);
      if (n == 0) begin
        b = 8'h00;
        a = 16'($urandom_range(0, 65535));
      end else begin
        b = 8'($urandom_range(1, 255));
        lim = (n == 1) ? 65535 : (int'(b) * 256 - 1);
        a = 16'($urandom_range(0, lim));
      end
      send(a, b);
    end
    rand_rdy = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
